cplx_mult_pipe: RTL and testbench



---
 rtl/cplx_pkg.sv | 59 +++++
 rtl/cplx_pipe_stage.sv | 39 +++
 rtl/cplx_mult_pipe.sv | 109 ++++++++++
 tb/tb_cplx_mult_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cplx_pkg.sv
// Shared definitions for the complex multiplier and the downstream accumulator.
package cplx_pkg;

    // Operand component, partial product and product component widths
    localparam int unsigned IW     = 16;
    localparam int unsigned PPW    = 2 * IW;
    localparam int unsigned PW     = 2 * IW + 1;
    localparam int unsigned CTRL_W = 2;
    localparam int unsigned PROD_W = 2 * PW;

    // Product-word field offsets: {re, im}
    localparam int unsigned RE_MSB = 2 * PW - 1;
    localparam int unsigned RE_LSB = PW;
    localparam int unsigned IM_MSB = PW - 1;
    localparam int unsigned IM_LSB = 0;

    // Accumulate control codes (2'b11 is reserved and treated as clear downstream)
    localparam logic [CTRL_W-1:0] CTRL_CLR = 2'b00;
    localparam logic [CTRL_W-1:0] CTRL_ACC = 2'b01;
    localparam logic [CTRL_W-1:0] CTRL_SUB = 2'b10;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // S1 payload: registered operands and code
    typedef struct packed {
        ctrl_t                 ctrl;
        logic signed [IW-1:0]  a_re;
        logic signed [IW-1:0]  a_im;
        logic signed [IW-1:0]  b_re;
        logic signed [IW-1:0]  b_im;
    } s1_t;

    // S2 payload: the four partial products and code
    typedef struct packed {
        ctrl_t                 ctrl;
        logic signed [PPW-1:0] rr;
        logic signed [PPW-1:0] ii;
        logic signed [PPW-1:0] ri;
        logic signed [PPW-1:0] ir;
    } s2_t;

    // S3 payload: the product word and code, as seen on the output ports
    typedef struct packed {
        ctrl_t                 ctrl;
        logic [PROD_W-1:0]     prod;
    } s3_t;

    // Exact signed product of two operand components
    function automatic logic signed [PPW-1:0] mul_pp(input logic signed [IW-1:0] x,
                                                     input logic signed [IW-1:0] y);
        return PPW'(x) * PPW'(y);
    endfunction

    // Sign-extend a partial product to product-component width
    function automatic logic [PW-1:0] sx_pp(input logic signed [PPW-1:0] p);
        return PW'(p);
    endfunction

endpackage

// File: rtl/cplx_pipe_stage.sv
// One valid/ready pipeline register slice. A slice loads whenever it is empty or
// its content is leaving this cycle, so bubbles collapse. On a drain with nothing
// to load, the held payload is ANDed with DRAIN_MASK so selected fields read zero
// while the slice is empty and the rest keep their last value.
module cplx_pipe_stage #(
    parameter int unsigned   W          = 8,
    parameter logic [W-1:0]  DRAIN_MASK = '1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         up_valid,
    output logic         up_ready_c,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    logic load_c;

    // Space available when empty or when the current word is being taken
    assign up_ready_c = ~dn_valid | dn_ready;
    assign load_c     = up_valid & up_ready_c;

    // Slice register: load, drain, or hold
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (load_c) begin
            dn_valid <= 1'b1;
            dn_data  <= up_data;
        end else if (dn_ready) begin
            dn_valid <= 1'b0;
            dn_data  <= dn_data & DRAIN_MASK;
        end
    end

endmodule

// File: rtl/cplx_mult_pipe.sv
// Pipelined signed complex multiplier: S1 operands, S2 partial products,
// S3 product word. Output bubbles carry a zero product and the last code so a
// free-running accumulator downstream holds its value.
module cplx_mult_pipe
    import cplx_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_ctrl,
    input  logic [2*IW-1:0]   in_a,
    input  logic [2*IW-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_ctrl,
    output logic [2*PW-1:0]   out_tmp
);

    localparam int unsigned S1W = $bits(s1_t);
    localparam int unsigned S2W = $bits(s2_t);
    localparam int unsigned S3W = $bits(s3_t);

    // Empty S3 keeps its code but presents a zero product
    localparam logic [S3W-1:0] S3_DRAIN_MASK = {{CTRL_W{1'b1}}, {PROD_W{1'b0}}};

    s1_t  s1_d;
    s1_t  s1_q;
    s2_t  s2_d;
    s2_t  s2_q;
    s3_t  s3_d;
    s3_t  s3_q;
    logic s1_valid;
    logic s2_valid;
    logic s2_ready_c;
    logic s3_ready_c;

    // Split operand words into components
    always_comb begin
        s1_d      = '0;
        s1_d.ctrl = in_ctrl;
        s1_d.a_re = in_a[2*IW-1:IW];
        s1_d.a_im = in_a[IW-1:0];
        s1_d.b_re = in_b[2*IW-1:IW];
        s1_d.b_im = in_b[IW-1:0];
    end

    // Four exact partial products
    always_comb begin
        s2_d      = '0;
        s2_d.ctrl = s1_q.ctrl;
        s2_d.rr   = mul_pp(s1_q.a_re, s1_q.b_re);
        s2_d.ii   = mul_pp(s1_q.a_im, s1_q.b_im);
        s2_d.ri   = mul_pp(s1_q.a_re, s1_q.b_im);
        s2_d.ir   = mul_pp(s1_q.a_im, s1_q.b_re);
    end

    // Real difference and imaginary sum at full product width
    always_comb begin
        s3_d                      = '0;
        s3_d.ctrl                 = s2_q.ctrl;
        s3_d.prod[RE_MSB:RE_LSB]  = sx_pp(s2_q.rr) - sx_pp(s2_q.ii);
        s3_d.prod[IM_MSB:IM_LSB]  = sx_pp(s2_q.ri) + sx_pp(s2_q.ir);
    end

    cplx_pipe_stage #(
        .W          (S1W)
    ) u_s1 (
        .clk        (clk),
        .n_rst      (n_rst),
        .up_valid   (in_valid),
        .up_ready_c (in_ready),
        .up_data    (s1_d),
        .dn_valid   (s1_valid),
        .dn_ready   (s2_ready_c),
        .dn_data    (s1_q)
    );

    cplx_pipe_stage #(
        .W          (S2W)
    ) u_s2 (
        .clk        (clk),
        .n_rst      (n_rst),
        .up_valid   (s1_valid),
        .up_ready_c (s2_ready_c),
        .up_data    (s2_d),
        .dn_valid   (s2_valid),
        .dn_ready   (s3_ready_c),
        .dn_data    (s2_q)
    );

    cplx_pipe_stage #(
        .W          (S3W),
        .DRAIN_MASK (S3_DRAIN_MASK)
    ) u_s3 (
        .clk        (clk),
        .n_rst      (n_rst),
        .up_valid   (s2_valid),
        .up_ready_c (s3_ready_c),
        .up_data    (s3_d),
        .dn_valid   (out_valid),
        .dn_ready   (out_ready),
        .dn_data    (s3_q)
    );

    assign out_ctrl = s3_q.ctrl;
    assign out_tmp  = s3_q.prod;

endmodule

// File: tb/tb_cplx_mult_pipe.sv
// Bench for cplx_mult_pipe: directed vector table, random streams, stall,
// bubble and mid-stream reset sequences, all checked through a scoreboard.
module tb_cplx_mult_pipe;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_ctrl = 2'b00;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_ctrl;
    logic [65:0] out_tmp;

    cplx_mult_pipe dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_tmp   (out_tmp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [67:0] exp;
    } vec_t;

    typedef struct {
        logic [67:0] exp;
        int          acc;
        bit          lat;
    } sb_t;

    vec_t        tbl[6];
    sb_t         q[$];
    sb_t         e;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    int          cyc = 0;
    logic [1:0]  last_ctrl = 2'b00;
    bit          prev_stall = 1'b0;
    logic [68:0] prev_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [67:0] model(input logic [1:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        longint ar, ai, br, bi, pr, pi;
        logic [63:0] ur, ui;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        pr = ar * br - ai * bi;
        pi = ar * bi + ai * br;
        ur = pr;
        ui = pi;
        return {c, ur[32:0], ui[32:0]};
    endfunction

    // Output monitor: scoreboard pops, latency, bubble content, stall stability
    always @(negedge clk) begin
        if (!n_rst) begin
            prev_stall = 1'b0;
            last_ctrl  = 2'b00;
        end else begin
            if (prev_stall)
                check("stall_hold", 72'({out_valid, out_ctrl, out_tmp}), 72'(prev_word));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h expected none", {out_ctrl, out_tmp});
                end else begin
                    e = q.pop_front();
                    check("product", 72'({out_ctrl, out_tmp}), 72'(e.exp));
                    if (e.lat)
                        check("latency", 72'(cyc - e.acc), 72'd3);
                end
                last_ctrl = out_ctrl;
            end else if (!out_valid) begin
                check("bubble", 72'({out_ctrl, out_tmp}), 72'({last_ctrl, 66'd0}));
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_valid, out_ctrl, out_tmp};
        end
    end

    // Present one operand pair, wait for acceptance, then idle for gap cycles
    task automatic send(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [67:0] exp, input int gap, input bit lat);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_a     = a;
        in_b     = b;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
        end else begin
            q.push_back('{exp, cyc, lat});
            n_acc++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rand(input int gap, input bit lat);
        logic [1:0]  c;
        logic [31:0] a, b;
        c = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
        send(c, a, b, model(c, a, b), gap, lat);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
        check("drain_empty", 72'(q.size()), 72'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2'b01, 32'h0003_0004, 32'h0001_0002, {2'b01, 33'h1_FFFF_FFFB, 33'h0_0000_000A}};
        tbl[1] = '{2'b10, 32'h8000_8000, 32'h8000_7FFF, {2'b10, 33'h0_7FFF_8000, 33'h0_0000_8000}};
        tbl[2] = '{2'b00, 32'h8000_8000, 32'h8000_8000, {2'b00, 33'h0_0000_0000, 33'h0_8000_0000}};
        tbl[3] = '{2'b11, 32'h7FFF_0000, 32'h7FFF_0000, {2'b11, 33'h0_3FFF_0001, 33'h0_0000_0000}};
        tbl[4] = '{2'b01, 32'hFFFF_FFFF, 32'h0001_0000, {2'b01, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF}};
        tbl[5] = '{2'b10, 32'h0000_0001, 32'h0000_0001, {2'b10, 33'h1_FFFF_FFFF, 33'h0_0000_0000}};

        // Reset and post-reset state
        repeat (2) @(negedge clk);
        check("in_reset_out", 72'({out_valid, out_ctrl, out_tmp}), 72'd0);
        #2;
        n_rst = 1'b1;
        @(negedge clk);
        check("reset_out", 72'({out_valid, out_ctrl, out_tmp}), 72'd0);
        check("reset_in_ready", 72'(in_ready), 72'd1);
        @(posedge clk);
        #1;

        // Directed vectors, back-to-back, unstalled
        for (int i = 0; i < 6; i++)
            send(tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].exp, 0, 1'b1);
        drain();

        // 20 random pairs back-to-back: latency 3 on every item means one per cycle
        for (int i = 0; i < 20; i++) send_rand(0, 1'b1);
        drain();

        // in_valid every other cycle: bubbles between products
        for (int i = 0; i < 8; i++) send_rand(1, 1'b1);
        drain();

        // Continuous input with out_ready low for 5 cycles
        n_acc     = 0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 20; i++) send_rand(0, 1'b0);
            end
            begin
                repeat (5) @(negedge clk);
                check("stall_in_ready", 72'(in_ready), 72'd0);
                check("stall_accepts", 72'(n_acc), 72'd3);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_total", 72'(n_acc), 72'd20);

        // Reset with three items in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand(0, 1'b0);
        check("full_out_valid", 72'(out_valid), 72'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_reset_out", 72'({out_valid, out_ctrl, out_tmp}), 72'd0);
        q.delete();
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        #1;
        check("post_reset_in_ready", 72'(in_ready), 72'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(tbl[0].c, tbl[0].a, tbl[0].b, tbl[0].exp, 0, 1'b1);
        drain();
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
